// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues word reads for each offered PC and pairs in-order
// responses with their PCs in a DEPTH-entry queue that feeds decode.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_i,
   input  logic            pc_valid_i,
   output logic            pc_ready_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            imem_err_i,
   input  logic            flush_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] inst_pc_o,
   output logic            inst_err_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]    wr_ptr, rd_ptr, fill_ptr;
   logic [CW-1:0]    occupancy, drop_cnt, pending;
   logic [DEPTH-1:0] filled;
   logic [DEPTH-1:0] err_mem;
   logic [XLEN-1:0]  pc_mem   [DEPTH];
   logic [XLEN-1:0]  inst_mem [DEPTH];

   logic [CW:0] committed;
   logic        credit_ok, issue, fill, drop, pop, flush_sub;

   // Stale responses still owed by memory hold credits just like live entries.
   assign committed = {1'b0, occupancy} + {1'b0, drop_cnt};
   assign credit_ok = committed < (CW + 1)'(DEPTH);

   assign imem_req_o  = pc_valid_i & credit_ok & ~flush_i & ~reset;
   assign imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
   assign pc_ready_o  = imem_req_o & imem_gnt_i;
   assign issue       = pc_ready_o;

   assign drop      = imem_rvalid_i & (drop_cnt != '0);
   assign fill      = imem_rvalid_i & (drop_cnt == '0) & (pending != '0) & ~flush_i;
   assign flush_sub = imem_rvalid_i & ((drop_cnt != '0) | (pending != '0));

   assign inst_valid_o = filled[rd_ptr] & (occupancy != '0) & ~flush_i;
   assign inst_o       = inst_mem[rd_ptr];
   assign inst_pc_o    = pc_mem[rd_ptr];
   assign inst_err_o   = err_mem[rd_ptr];
   assign pop          = inst_valid_o & inst_ready_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_ptr  <= '0;
         occupancy <= '0;
         drop_cnt  <= '0;
         pending   <= '0;
         filled    <= '0;
         err_mem   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]   <= '0;
            inst_mem[i] <= '0;
         end
      end else if (flush_i) begin
         // Every unfilled entry becomes a response to throw away on arrival.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill_ptr  <= '0;
         occupancy <= '0;
         pending   <= '0;
         filled    <= '0;
         drop_cnt  <= drop_cnt + pending - CW'(flush_sub);
      end else begin
         if (issue) begin
            pc_mem[wr_ptr] <= pc_i;
            filled[wr_ptr] <= 1'b0;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (fill) begin
            inst_mem[fill_ptr] <= imem_rdata_i;
            err_mem[fill_ptr]  <= imem_err_i;
            filled[fill_ptr]   <= 1'b1;
            fill_ptr           <= fill_ptr + PW'(1);
         end
         if (drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (pop) begin
            filled[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + PW'(1);
         end
         occupancy <= occupancy + CW'(issue) - CW'(pop);
         pending   <= pending + CW'(issue) - CW'(fill);
      end
   end

   unsolicited_rvalid: assert property (@(posedge clk) disable iff (reset)
      imem_rvalid_i |-> ((pending != '0) || (drop_cnt != '0)));

endmodule
